// File: rtl/serial_adder_sub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int calc_n(input int w, input int d);
        return w / d;
    endfunction

    function automatic int calc_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_sub_fa_slice.sv
// D-bit ripple full-adder slice; also exports the carry into its top bit cell.
// Latency: combinational.
// Backpressure: none.
module fa_slice #(
    parameter int D = 1
) (
    input  logic [D-1:0] a,
    input  logic [D-1:0] b,
    input  logic         ci,
    output logic [D-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [D:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{D{1'b0}}, ci};
    assign s     = total[D-1:0];
    assign co    = total[D];

    // The top cell computes s = a ^ b ^ c_in, so its carry-in falls out of the sum bit.
    assign c_msb_in = s[D-1] ^ a[D-1] ^ b[D-1];

endmodule

// File: rtl/serial_adder_sub.sv
// Digit-serial W-bit add/subtract, one D-bit digit per clock, LS digit first.
// Latency: start at edge E0 -> done pulse in the cycle after edge E0+W/D.
// Backpressure: start is ignored while busy; no queuing.
module serial_adder_sub
    import serial_adder_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int N  = calc_n(W, D);
    localparam int CW = calc_cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic [W-1:0]  s_sr;
    logic [W-1:0]  s_next;
    logic [W-1:0]  dig_ext;
    logic          carry;
    logic [D-1:0]  dig_s;
    logic          dig_co;
    logic          dig_cmsb;

    fa_slice #(.D(D)) u_fa_slice (
        .a        (a_sr[D-1:0]),
        .b        (b_sr[D-1:0]),
        .ci       (carry),
        .s        (dig_s),
        .co       (dig_co),
        .c_msb_in (dig_cmsb)
    );

    // New digit enters at the top; after N shifts the first digit sits at bit 0.
    assign dig_ext = W'(dig_s);
    assign s_next  = (s_sr >> D) | (dig_ext << (W - D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= sub | cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> D;
                    b_sr  <= b_sr >> D;
                    s_sr  <= s_next;
                    carry <= dig_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= s_next;
                        cout  <= dig_co;
                        ovf   <= dig_cmsb ^ dig_co;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_sub.sv
// Directed and randomised checks of serial_adder_sub at W/D = 8/1, 8/4 and 16/4.
// A transaction-level model predicts every output each cycle; literal vectors pin it.
module tb_serial_adder_sub;

    logic clk;
    logic rst_n;

    logic        st0, sb0, ci0, bz0, dn0, co0, ov0;
    logic [7:0]  a0, b0, s0;
    logic        st1, sb1, ci1, bz1, dn1, co1, ov1;
    logic [7:0]  a1, b1, s1;
    logic        st2, sb2, ci2, bz2, dn2, co2, ov2;
    logic [15:0] a2, b2, s2;

    int checks = 0;
    int errs   = 0;

    serial_adder_sub #(.W(8), .D(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(st0), .sub(sb0), .a(a0), .b(b0), .cin(ci0),
        .busy(bz0), .done(dn0), .sum(s0), .cout(co0), .ovf(ov0)
    );
    serial_adder_sub #(.W(8), .D(4)) u1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .sub(sb1), .a(a1), .b(b1), .cin(ci1),
        .busy(bz1), .done(dn1), .sum(s1), .cout(co1), .ovf(ov1)
    );
    serial_adder_sub #(.W(16), .D(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .sub(sb2), .a(a2), .b(b2), .cin(ci2),
        .busy(bz2), .done(dn2), .sum(s2), .cout(co2), .ovf(ov2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction model: an accepted op finishes n edges later with the result
    // of plain W-bit arithmetic.
    typedef struct packed {
        logic        busy;
        logic        done;
        logic [4:0]  left;
        logic [15:0] pa;
        logic [15:0] pb;
        logic        psub;
        logic        pcin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } mdl_t;

    mdl_t m0 = '0;
    mdl_t m1 = '0;
    mdl_t m2 = '0;

    function automatic mdl_t mstep(mdl_t m, logic st, logic sb, logic [15:0] a, logic [15:0] b,
                                   logic ci, int w, int n);
        mdl_t        r;
        logic [15:0] mask, aa, bb, res;
        logic [16:0] full;
        r      = m;
        r.done = 1'b0;
        if (!m.busy) begin
            if (st) begin
                r.busy = 1'b1;
                r.left = 5'(n);
                r.pa   = a;
                r.pb   = b;
                r.psub = sb;
                r.pcin = ci;
            end
        end else begin
            r.left = m.left - 5'd1;
            if (r.left == 5'd0) begin
                mask   = 16'((17'h1 << w) - 17'h1);
                aa     = m.pa & mask;
                bb     = m.psub ? (~m.pb & mask) : (m.pb & mask);
                full   = 17'(aa) + 17'(bb) + 17'(m.psub ? 1'b1 : m.pcin);
                res    = full[15:0] & mask;
                r.busy = 1'b0;
                r.done = 1'b1;
                r.sum  = res;
                r.cout = full[w];
                r.ovf  = (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= '0;
            m1 <= '0;
            m2 <= '0;
        end else begin
            m0 <= mstep(m0, st0, sb0, {8'h00, a0}, {8'h00, b0}, ci0, 8, 8);
            m1 <= mstep(m1, st1, sb1, {8'h00, a1}, {8'h00, b1}, ci1, 8, 2);
            m2 <= mstep(m2, st2, sb2, a2, b2, ci2, 16, 4);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("u0 busy", 32'(bz0), 32'(m0.busy));
                chk("u0 done", 32'(dn0), 32'(m0.done));
                chk("u0 res",  {15'h0, s0, co0, ov0},  {15'h0, m0.sum[7:0], m0.cout, m0.ovf});
                chk("u1 busy", 32'(bz1), 32'(m1.busy));
                chk("u1 done", 32'(dn1), 32'(m1.done));
                chk("u1 res",  {15'h0, s1, co1, ov1},  {15'h0, m1.sum[7:0], m1.cout, m1.ovf});
                chk("u2 busy", 32'(bz2), 32'(m2.busy));
                chk("u2 done", 32'(dn2), 32'(m2.done));
                chk("u2 res",  {7'h0, s2, co2, ov2, 7'h0}, {7'h0, m2.sum, m2.cout, m2.ovf, 7'h0});
            end
        end
    end

    task automatic set_in(input int sel, input logic st, input logic sb,
                          input logic [15:0] a, input logic [15:0] b, input logic ci);
        case (sel)
            0:       begin st0 = st; sb0 = sb; a0 = a[7:0]; b0 = b[7:0]; ci0 = ci; end
            1:       begin st1 = st; sb1 = sb; a1 = a[7:0]; b1 = b[7:0]; ci1 = ci; end
            default: begin st2 = st; sb2 = sb; a2 = a;      b2 = b;      ci2 = ci; end
        endcase
    endtask

    function automatic logic get_dn(input int sel);
        case (sel)
            0:       return dn0;
            1:       return dn1;
            default: return dn2;
        endcase
    endfunction

    function automatic logic [17:0] get_res(input int sel);
        case (sel)
            0:       return {8'h00, s0, co0, ov0};
            1:       return {8'h00, s1, co1, ov1};
            default: return {s2, co2, ov2};
        endcase
    endfunction

    // Start lasts one edge; inputs are then scrambled to prove they were latched.
    task automatic do_start(input int sel, input logic sb, input logic [15:0] a,
                            input logic [15:0] b, input logic ci);
        #1;
        set_in(sel, 1'b1, sb, a, b, ci);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, ~sb, ~a, ~b, ~ci);
    endtask

    // Returns at the falling edge inside the done cycle.
    task automatic wait_done(input int sel, input string nm, input int exp_lat,
                             input logic [15:0] es, input logic ec, input logic eo, input int inj);
        int   c;
        logic seen;
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 40) begin
            @(negedge clk);
            c++;
            if (inj != 0 && c == inj)     set_in(sel, 1'b1, 1'b0, 16'h1234, 16'h4321, 1'b1);
            if (inj != 0 && c == inj + 1) set_in(sel, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
            if (get_dn(sel) === 1'b1) seen = 1'b1;
        end
        chk({nm, " latency"}, 32'(c), 32'(exp_lat));
        chk({nm, " result"}, 32'(get_res(sel)), 32'({es, ec, eo}));
    endtask

    initial begin
        logic [15:0] ra, rb, rres;
        logic [16:0] t;
        logic        rs, rc, ec, eo;
        int          seen;

        rst_n = 1'b0;
        set_in(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_in(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_in(2, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reset u0", {13'h0, bz0, dn0, s0, co0, ov0, 6'h0}, 32'h0);
        chk("reset u1", {13'h0, bz1, dn1, s1, co1, ov1, 6'h0}, 32'h0);
        chk("reset u2", {10'h0, bz2, dn2, s2, co2, ov2}, 32'h0);
        #1 rst_n = 1'b1;

        do_start(0, 1'b0, 16'h5A, 16'h3C, 1'b0);
        wait_done(0, "add 5A+3C", 9, 16'h96, 1'b0, 1'b1, 0);
        do_start(0, 1'b0, 16'hFF, 16'h01, 1'b0);
        wait_done(0, "add FF+01", 9, 16'h00, 1'b1, 1'b0, 0);
        do_start(0, 1'b0, 16'h00, 16'h00, 1'b1);
        wait_done(0, "add 00+00+1", 9, 16'h01, 1'b0, 1'b0, 0);
        do_start(0, 1'b1, 16'h10, 16'h20, 1'b1);
        wait_done(0, "sub 10-20", 9, 16'hF0, 1'b0, 1'b0, 0);
        do_start(0, 1'b1, 16'h80, 16'h01, 1'b0);
        wait_done(0, "sub 80-01", 9, 16'h7F, 1'b1, 1'b1, 0);

        // start pulsed mid-run must not disturb the operation
        do_start(0, 1'b0, 16'h21, 16'h43, 1'b0);
        wait_done(0, "ignore busy start", 9, 16'h64, 1'b0, 1'b0, 3);

        // start raised inside the done cycle is accepted
        do_start(0, 1'b0, 16'h7F, 16'h01, 1'b0);
        wait_done(0, "b2b first", 9, 16'h80, 1'b0, 1'b1, 0);
        do_start(0, 1'b1, 16'h05, 16'h07, 1'b0);
        wait_done(0, "b2b second", 9, 16'hFE, 1'b0, 1'b0, 0);

        // asynchronous reset mid-operation
        do_start(0, 1'b0, 16'hAA, 16'h11, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid reset u0", {13'h0, bz0, dn0, s0, co0, ov0, 6'h0}, 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn0 === 1'b1) seen++;
        end
        chk("no done after reset", 32'(seen), 32'd0);

        do_start(1, 1'b0, 16'hC8, 16'h64, 1'b0);
        wait_done(1, "d4 add C8+64", 3, 16'h2C, 1'b1, 1'b0, 0);
        do_start(1, 1'b1, 16'h00, 16'h00, 1'b0);
        wait_done(1, "d4 sub 00-00", 3, 16'h00, 1'b1, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            if (i == 0) begin ra = 16'hFFFF; rb = 16'h0000; rs = 1'b0; rc = 1'b1; end
            if (i == 1) begin ra = 16'h8000; rb = 16'h7FFF; rs = 1'b1; rc = 1'b0; end
            if (rs) begin
                rres = ra - rb;
                ec   = (ra >= rb);
                eo   = (ra[15] != rb[15]) && (rres[15] != ra[15]);
            end else begin
                t    = 17'(ra) + 17'(rb) + 17'(rc);
                rres = t[15:0];
                ec   = t[16];
                eo   = (ra[15] == rb[15]) && (rres[15] != ra[15]);
            end
            do_start(2, rs, ra, rb, rc);
            wait_done(2, "w16 random", 5, rres, ec, eo, 0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
